host_rsp_model: RTL and testbench
=================================

HOST_RSP_MODEL -- requirements
Module: host_rsp_model

Interface
REQ-001 Parameter addr_width, default 64, host effective-address width in bits SHALL be supported.
REQ-002 Parameter cache_line, default 128, host cache-line size in bytes; cache_line_width = $clog2(cache_line) SHALL be derived.
REQ-003 Parameter nstrms, default 64, number of streams; nstrms_width = $clog2(nstrms) SHALL be derived.
REQ-004 Parameter depth, default 16, maximum outstanding requests (power of two, >=2) SHALL be supported.
REQ-005 Parameter latency, default 32, minimum request-to-response delay in cycles (>=1) SHALL be supported.
REQ-006 Port clk  input  1  single clock; all state on rising edge.
REQ-007 Port reset  input  1  asynchronous, active-high reset.
REQ-008 Ports i_req_v input 1 / i_req_r output 1  host request valid/ready.
REQ-009 Ports i_req_sid input nstrms_width / i_req_ea input addr_width  requesting stream id, effective address.
REQ-010 Ports o_rsp_v output 1 / o_rsp_r input 1  host response valid/ready.
REQ-011 Ports o_rsp_sid output nstrms_width / o_rsp_ea output addr_width  stream id and address of completed request.
REQ-012 Port o_rsp_err output 1  completed request had ea not cache-line aligned.
REQ-013 Port o_cnt output $clog2(depth+1)  number of outstanding requests.

Function
REQ-014 Handshake: transfer occurs on a rising edge where v and r are both high; v SHALL NOT depend combinationally on r; o_rsp_* SHALL hold stable while o_rsp_v=1 and o_rsp_r=0.
REQ-015 Accepted requests SHALL be stored in an in-order circular buffer of depth entries {sid, ea, err, countdown}.
REQ-016 i_req_r SHALL be 1 iff o_cnt < depth; when full, i_req_r=0 even in a cycle where a response is dequeued.
REQ-017 On acceptance, entry countdown SHALL load latency-1 and decrement each cycle, saturating at 0, independent of position in buffer.
REQ-018 o_rsp_v SHALL be 1 iff buffer non-empty and head countdown = 0; a request accepted at edge T produces o_rsp_v=1 from the cycle after edge T+latency-1, i.e. exactly latency cycles later with no backpressure.
REQ-019 Responses SHALL be returned strictly in acceptance order; back-to-back accepts yield back-to-back responses with o_rsp_r=1.
REQ-020 err SHALL be captured as (i_req_ea[cache_line_width-1:0] != 0); misaligned requests complete normally with o_rsp_err=1.
REQ-021 Simultaneous accept and dequeue SHALL leave o_cnt unchanged; accept only +1; dequeue only -1.
REQ-022 Read and write pointers SHALL wrap modulo depth; full/empty SHALL be distinguished via o_cnt.
REQ-023 Empty buffer: o_rsp_v=0, o_rsp_sid/ea/err hold last values (don't-care for checking).

Reset
REQ-024 reset=1 SHALL asynchronously clear pointers, o_cnt=0, o_rsp_v=0, o_rsp_err=0, o_rsp_sid=0, o_rsp_ea=0; i_req_r=1 from the first edge after reset release.
REQ-025 Reset mid-operation SHALL discard all outstanding entries; no response for any pre-reset request SHALL appear.

Structure
REQ-026 Shared package msb_pkg SHALL hold default addr_width, cache_line, nstrms constants and the entry struct typedef.
REQ-027 One sub-module host_rsp_slot SHALL implement a single entry (payload register plus saturating countdown), instantiated depth times.
REQ-028 Valid/ready handshake on both interfaces SHALL use the existing base register-slice conventions; no combinational path from i_req_v to o_rsp_v.

Verification
REQ-029 Single request sid=5, ea=0x1000 at cycle 10, o_rsp_r=1 -> o_rsp_v=1 at cycle 42, sid=5, ea=0x1000, err=0, o_cnt returns to 0.
REQ-030 16 back-to-back requests sid=0..15, o_rsp_r=0 -> i_req_r=0 after 16th, o_cnt=16; release o_rsp_r -> sid 0..15 in order, one per cycle.
REQ-031 Request ea=0x1040 -> response with o_rsp_err=1, sid/ea echoed unchanged.
REQ-032 Full buffer with o_rsp_r=1 and i_req_v=1 -> dequeue only, o_cnt=15, next cycle i_req_r=1 and accept, o_cnt=15.
REQ-033 Pointer wrap: 40 requests at random 0-3 cycle gaps, random o_rsp_r -> all 40 responses in order, none lost or duplicated, each >= 32 cycles after accept.
REQ-034 Assert reset with 7 outstanding -> o_rsp_v=0 and o_cnt=0 immediately; after release, no stale response within 64 cycles.

Source files
------------

// File: rtl/msb_pkg.sv
// Shared defaults and the stored-entry layout for the host response model.
// The entry struct matches the default parameter set; other sizes use a local struct.
package msb_pkg;

   localparam int ADDR_WIDTH_DEF = 64;
   localparam int CACHE_LINE_DEF = 128;
   localparam int NSTRMS_DEF     = 64;
   localparam int NSTRMS_W_DEF   = $clog2(NSTRMS_DEF);

   typedef struct packed {
      logic [NSTRMS_W_DEF-1:0]   sid;
      logic [ADDR_WIDTH_DEF-1:0] ea;
      logic                      err;
   } rsp_entry_t;

endpackage

// File: rtl/host_rsp_slot.sv
// One outstanding-request entry: payload register plus a countdown that
// starts at latency-1 when loaded and saturates at zero.
module host_rsp_slot
   import msb_pkg::*;
#(
   parameter type entry_t = rsp_entry_t,
   parameter int  latency = 32
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   load_i,
   input  entry_t data_i,
   output entry_t data_o,
   output logic   zero_o
);

   localparam int cdWidth = $clog2(latency + 1);

   entry_t               data_q;
   logic [cdWidth-1:0]   countdown_q;

   // The countdown keeps running wherever the entry sits in the ring, so the
   // head is ready as soon as it arrives if its delay already elapsed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q      <= '0;
         countdown_q <= '0;
      end else if (load_i) begin
         data_q      <= data_i;
         countdown_q <= cdWidth'(latency - 1);
      end else if (countdown_q != '0) begin
         countdown_q <= countdown_q - 1'b1;
      end
   end

   assign data_o = data_q;
   assign zero_o = (countdown_q == '0);

endmodule

// File: rtl/host_rsp_model.sv
// Host response model: accepts requests into an in-order ring of slots and
// returns each one no earlier than latency cycles after acceptance.
module host_rsp_model
   import msb_pkg::*;
#(
   parameter int addr_width = ADDR_WIDTH_DEF,
   parameter int cache_line = CACHE_LINE_DEF,
   parameter int nstrms     = NSTRMS_DEF,
   parameter int depth      = 16,
   parameter int latency    = 32,
   localparam int cache_line_width = $clog2(cache_line),
   localparam int nstrms_width     = $clog2(nstrms),
   localparam int cnt_width        = $clog2(depth + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_req_v,
   output logic                    i_req_r,
   input  logic [nstrms_width-1:0] i_req_sid,
   input  logic [addr_width-1:0]   i_req_ea,
   output logic                    o_rsp_v,
   input  logic                    o_rsp_r,
   output logic [nstrms_width-1:0] o_rsp_sid,
   output logic [addr_width-1:0]   o_rsp_ea,
   output logic                    o_rsp_err,
   output logic [cnt_width-1:0]    o_cnt
);

   typedef struct packed {
      logic [nstrms_width-1:0] sid;
      logic [addr_width-1:0]   ea;
      logic                    err;
   } entry_t;

   localparam int                   ptrWidth = $clog2(depth);
   localparam logic [cnt_width-1:0] depthCnt = cnt_width'(depth);

   logic [ptrWidth-1:0]  wrPtr_q, wrPtr_d;
   logic [ptrWidth-1:0]  rdPtr_q, rdPtr_d;
   logic [cnt_width-1:0] cnt_q, cnt_d;
   logic                 accept;
   logic                 dequeue;
   entry_t               reqEntry;
   entry_t               headEntry;
   entry_t               slotData [depth];
   logic [depth-1:0]     slotLoad;
   logic [depth-1:0]     slotZero;

   // Both valid and ready come straight from registers, so neither side sees
   // a combinational path from the other side's handshake inputs.
   assign i_req_r   = (cnt_q < depthCnt);
   assign accept    = i_req_v & i_req_r;
   assign o_rsp_v   = (cnt_q != '0) & slotZero[rdPtr_q];
   assign dequeue   = o_rsp_v & o_rsp_r;
   assign headEntry = slotData[rdPtr_q];
   assign o_rsp_sid = headEntry.sid;
   assign o_rsp_ea  = headEntry.ea;
   assign o_rsp_err = headEntry.err;
   assign o_cnt     = cnt_q;

   always_comb begin
      reqEntry     = '0;
      reqEntry.sid = i_req_sid;
      reqEntry.ea  = i_req_ea;
      reqEntry.err = (i_req_ea[cache_line_width-1:0] != '0);
   end

   // Pointers wrap naturally because depth is a power of two; the occupancy
   // count is what tells full apart from empty.
   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      cnt_d   = cnt_q;
      if (accept) begin
         wrPtr_d = wrPtr_q + 1'b1;
      end
      if (dequeue) begin
         rdPtr_d = rdPtr_q + 1'b1;
      end
      case ({accept, dequeue})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         cnt_q   <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         cnt_q   <= cnt_d;
      end
   end

   for (genvar g = 0; g < depth; g++) begin : gSlot
      assign slotLoad[g] = accept && (wrPtr_q == ptrWidth'(g));

      host_rsp_slot #(
         .entry_t (entry_t),
         .latency (latency)
      ) uSlot (
         .clk    (clk),
         .reset  (reset),
         .load_i (slotLoad[g]),
         .data_i (reqEntry),
         .data_o (slotData[g]),
         .zero_o (slotZero[g])
      );
   end

endmodule

// File: tb/tb_host_rsp_model.sv
// Self-checking bench for host_rsp_model: directed scenarios plus a randomized
// run compared against a queue-based reference of the response rules.
module tb_host_rsp_model;

   localparam int DEPTH = 16;
   localparam int LAT   = 32;
   localparam int CL    = 128;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req_v;
   logic        i_req_r;
   logic [5:0]  i_req_sid;
   logic [63:0] i_req_ea;
   logic        o_rsp_v;
   logic        o_rsp_r;
   logic [5:0]  o_rsp_sid;
   logic [63:0] o_rsp_ea;
   logic        o_rsp_err;
   logic [4:0]  o_cnt;

   int errCount   = 0;
   int checkCount = 0;

   always #5 clk = ~clk;

   host_rsp_model dut (
      .clk       (clk),
      .reset     (reset),
      .i_req_v   (i_req_v),
      .i_req_r   (i_req_r),
      .i_req_sid (i_req_sid),
      .i_req_ea  (i_req_ea),
      .o_rsp_v   (o_rsp_v),
      .o_rsp_r   (o_rsp_r),
      .o_rsp_sid (o_rsp_sid),
      .o_rsp_ea  (o_rsp_ea),
      .o_rsp_err (o_rsp_err),
      .o_cnt     (o_cnt)
   );

   // Reference: a FIFO of accepted requests, each tagged with the cycle number
   // from which it may be returned; the head is returnable once that cycle is reached.
   typedef struct {
      logic [5:0]  sid;
      logic [63:0] ea;
      logic        err;
      int          readyAt;
   } exp_t;

   exp_t mq[$];
   int   mcyc = 0;

   function automatic bit modelValid();
      return (mq.size() > 0) && (mcyc >= mq[0].readyAt);
   endfunction

   always @(posedge clk or posedge reset) begin
      bit   popNow;
      bit   pushNow;
      exp_t e;
      if (reset) begin
         mq.delete();
      end else begin
         popNow  = modelValid() && (o_rsp_r === 1'b1);
         pushNow = (i_req_v === 1'b1) && (mq.size() < DEPTH);
         mcyc++;
         if (popNow) void'(mq.pop_front());
         if (pushNow) begin
            e.sid     = i_req_sid;
            e.ea      = i_req_ea;
            e.err     = (i_req_ea % CL) != 0;
            e.readyAt = mcyc + LAT - 1;
            mq.push_back(e);
         end
      end
   end

   task automatic test_reset();
      reset = 1'b1; i_req_v = 1'b0; o_rsp_r = 1'b0; i_req_sid = '0; i_req_ea = '0;
      repeat (3) @(negedge clk);
      checkCount++; if (o_rsp_v !== 1'b0) begin errCount++; $display("FAIL reset_v: got %0b want 0", o_rsp_v); end
      checkCount++; if (o_cnt !== 5'd0) begin errCount++; $display("FAIL reset_cnt: got %0d want 0", o_cnt); end
      checkCount++; if (o_rsp_sid !== 6'd0) begin errCount++; $display("FAIL reset_sid: got %0d want 0", o_rsp_sid); end
      checkCount++; if (o_rsp_ea !== 64'd0) begin errCount++; $display("FAIL reset_ea: got %0h want 0", o_rsp_ea); end
      checkCount++; if (o_rsp_err !== 1'b0) begin errCount++; $display("FAIL reset_err: got %0b want 0", o_rsp_err); end
      reset = 1'b0;
      @(negedge clk);
      checkCount++; if (i_req_r !== 1'b1) begin errCount++; $display("FAIL reset_ready: got %0b want 1", i_req_r); end
   endtask

   task automatic test_single();
      i_req_sid = 6'd5; i_req_ea = 64'h1000; i_req_v = 1'b1; o_rsp_r = 1'b1;
      @(negedge clk);
      i_req_v = 1'b0;
      checkCount++; if (o_cnt !== 5'd1) begin errCount++; $display("FAIL single_cnt1: got %0d want 1", o_cnt); end
      for (int j = 0; j <= LAT + 1; j++) begin
         checkCount++;
         if (o_rsp_v !== (j == LAT - 1)) begin
            errCount++; $display("FAIL single_v at %0d: got %0b want %0b", j, o_rsp_v, (j == LAT - 1));
         end
         if (j == LAT - 1) begin
            checkCount++; if (o_rsp_sid !== 6'd5) begin errCount++; $display("FAIL single_sid: got %0d want 5", o_rsp_sid); end
            checkCount++; if (o_rsp_ea !== 64'h1000) begin errCount++; $display("FAIL single_ea: got %0h want 1000", o_rsp_ea); end
            checkCount++; if (o_rsp_err !== 1'b0) begin errCount++; $display("FAIL single_err: got %0b want 0", o_rsp_err); end
         end
         @(negedge clk);
      end
      checkCount++; if (o_cnt !== 5'd0) begin errCount++; $display("FAIL single_cnt0: got %0d want 0", o_cnt); end
   endtask

   task automatic test_back_to_back();
      o_rsp_r = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         i_req_sid = 6'(i); i_req_ea = 64'(i * CL); i_req_v = 1'b1;
         @(negedge clk);
      end
      i_req_sid = 6'd63; i_req_ea = 64'h0;
      checkCount++; if (i_req_r !== 1'b0) begin errCount++; $display("FAIL b2b_full_ready: got %0b want 0", i_req_r); end
      checkCount++; if (o_cnt !== 5'd16) begin errCount++; $display("FAIL b2b_cnt16: got %0d want 16", o_cnt); end
      @(negedge clk);
      i_req_v = 1'b0;
      checkCount++; if (o_cnt !== 5'd16) begin errCount++; $display("FAIL b2b_no_overfill: got %0d want 16", o_cnt); end
      repeat (LAT) @(negedge clk);
      o_rsp_r = 1'b1;
      for (int n = 0; n < DEPTH; n++) begin
         checkCount++;
         if (o_rsp_v !== 1'b1 || o_rsp_sid !== 6'(n) || o_rsp_ea !== 64'(n * CL)) begin
            errCount++; $display("FAIL b2b_order %0d: got v=%0b sid=%0d ea=%0h want v=1 sid=%0d ea=%0h",
                                 n, o_rsp_v, o_rsp_sid, o_rsp_ea, n, n * CL);
         end
         @(negedge clk);
      end
      checkCount++; if (o_rsp_v !== 1'b0 || o_cnt !== 5'd0) begin errCount++; $display("FAIL b2b_empty: got v=%0b cnt=%0d want v=0 cnt=0", o_rsp_v, o_cnt); end
      o_rsp_r = 1'b0;
   endtask

   task automatic test_misaligned();
      bit seen = 1'b0;
      i_req_sid = 6'd9; i_req_ea = 64'h1040; i_req_v = 1'b1; o_rsp_r = 1'b1;
      @(negedge clk);
      i_req_v = 1'b0;
      for (int k = 0; k < 64 && !seen; k++) begin
         if (o_rsp_v === 1'b1) begin
            seen = 1'b1;
            checkCount++; if (o_rsp_err !== 1'b1) begin errCount++; $display("FAIL mis_err: got %0b want 1", o_rsp_err); end
            checkCount++; if (o_rsp_sid !== 6'd9) begin errCount++; $display("FAIL mis_sid: got %0d want 9", o_rsp_sid); end
            checkCount++; if (o_rsp_ea !== 64'h1040) begin errCount++; $display("FAIL mis_ea: got %0h want 1040", o_rsp_ea); end
         end
         @(negedge clk);
      end
      checkCount++; if (!seen) begin errCount++; $display("FAIL mis_timeout: got no response want one within 64 cycles"); end
      checkCount++; if (o_cnt !== 5'd0) begin errCount++; $display("FAIL mis_cnt: got %0d want 0", o_cnt); end
      o_rsp_r = 1'b0;
   endtask

   task automatic test_full_dequeue();
      o_rsp_r = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         i_req_sid = 6'(i); i_req_ea = 64'(i * CL); i_req_v = 1'b1;
         @(negedge clk);
      end
      i_req_v = 1'b0;
      repeat (LAT) @(negedge clk);
      checkCount++; if (o_cnt !== 5'd16 || i_req_r !== 1'b0 || o_rsp_v !== 1'b1) begin
         errCount++; $display("FAIL full_pre: got cnt=%0d r=%0b v=%0b want cnt=16 r=0 v=1", o_cnt, i_req_r, o_rsp_v);
      end
      i_req_sid = 6'd20; i_req_ea = 64'h2000; i_req_v = 1'b1; o_rsp_r = 1'b1;
      @(negedge clk);
      checkCount++; if (o_cnt !== 5'd15) begin errCount++; $display("FAIL full_deq_only: got %0d want 15", o_cnt); end
      checkCount++; if (i_req_r !== 1'b1) begin errCount++; $display("FAIL full_ready_back: got %0b want 1", i_req_r); end
      checkCount++; if (o_rsp_sid !== 6'd1) begin errCount++; $display("FAIL full_head: got %0d want 1", o_rsp_sid); end
      @(negedge clk);
      i_req_v = 1'b0;
      checkCount++; if (o_cnt !== 5'd15) begin errCount++; $display("FAIL full_acc_deq: got %0d want 15", o_cnt); end
      for (int k = 0; k < 200 && o_cnt !== 5'd0; k++) @(negedge clk);
      checkCount++; if (o_cnt !== 5'd0) begin errCount++; $display("FAIL full_drain: got %0d want 0", o_cnt); end
      o_rsp_r = 1'b0;
   endtask

   task automatic test_wrap_random();
      int          issued = 0;
      int          got = 0;
      int          gap = 0;
      bit          justAccepted = 1'b0;
      int          acceptAt [40];
      logic [63:0] eaArr [40];
      for (int i = 0; i < 40; i++) begin
         eaArr[i] = {$urandom, $urandom};
         if ($urandom_range(0, 1) == 1) eaArr[i][6:0] = 7'd0;
      end
      i_req_v = 1'b0;
      for (int cyc = 0; cyc < 3000 && got < 40; cyc++) begin
         checkCount++; if (o_rsp_v !== modelValid()) begin errCount++; $display("FAIL rnd_v cyc %0d: got %0b want %0b", cyc, o_rsp_v, modelValid()); end
         checkCount++; if (o_cnt !== 5'(mq.size())) begin errCount++; $display("FAIL rnd_cnt cyc %0d: got %0d want %0d", cyc, o_cnt, mq.size()); end
         checkCount++; if (i_req_r !== (mq.size() < DEPTH)) begin errCount++; $display("FAIL rnd_ready cyc %0d: got %0b want %0b", cyc, i_req_r, (mq.size() < DEPTH)); end
         if (modelValid() && o_rsp_v === 1'b1) begin
            checkCount++;
            if (o_rsp_sid !== mq[0].sid || o_rsp_ea !== mq[0].ea || o_rsp_err !== mq[0].err) begin
               errCount++; $display("FAIL rnd_payload cyc %0d: got sid=%0d ea=%0h err=%0b want sid=%0d ea=%0h err=%0b",
                                    cyc, o_rsp_sid, o_rsp_ea, o_rsp_err, mq[0].sid, mq[0].ea, mq[0].err);
            end
         end
         o_rsp_r = 1'($urandom_range(0, 1));
         if (justAccepted) i_req_v = 1'b0;
         justAccepted = 1'b0;
         if (i_req_v == 1'b0 && issued < 40) begin
            if (gap > 0) gap--;
            else begin i_req_v = 1'b1; i_req_sid = 6'(issued); i_req_ea = eaArr[issued]; end
         end
         #1;
         if (o_rsp_v === 1'b1 && o_rsp_r === 1'b1) begin
            checkCount++;
            if (got >= issued) begin
               errCount++; $display("FAIL rnd_extra: got response %0d want at most %0d", got, issued);
            end else begin
               if (o_rsp_sid !== 6'(got) || o_rsp_ea !== eaArr[got]) begin
                  errCount++; $display("FAIL rnd_order %0d: got sid=%0d ea=%0h want sid=%0d ea=%0h", got, o_rsp_sid, o_rsp_ea, got, eaArr[got]);
               end
               checkCount++;
               if (cyc - acceptAt[got] < LAT) begin
                  errCount++; $display("FAIL rnd_latency %0d: got %0d cycles want >= %0d", got, cyc - acceptAt[got], LAT);
               end
            end
            got++;
         end
         if (i_req_v === 1'b1 && i_req_r === 1'b1) begin
            acceptAt[issued] = cyc;
            issued++;
            gap = $urandom_range(0, 3);
            justAccepted = 1'b1;
         end
         @(negedge clk);
      end
      i_req_v = 1'b0;
      checkCount++; if (got != 40 || issued != 40) begin errCount++; $display("FAIL rnd_total: got %0d of %0d issued want 40 of 40", got, issued); end
      o_rsp_r = 1'b0;
   endtask

   task automatic test_reset_mid();
      o_rsp_r = 1'b0;
      for (int i = 0; i < 7; i++) begin
         i_req_sid = 6'(30 + i); i_req_ea = 64'(i * CL); i_req_v = 1'b1;
         @(negedge clk);
      end
      i_req_v = 1'b0;
      repeat (LAT) @(negedge clk);
      checkCount++; if (o_cnt !== 5'd7 || o_rsp_v !== 1'b1) begin errCount++; $display("FAIL rstmid_pre: got cnt=%0d v=%0b want cnt=7 v=1", o_cnt, o_rsp_v); end
      reset = 1'b1;
      #1;
      checkCount++; if (o_rsp_v !== 1'b0) begin errCount++; $display("FAIL rstmid_v: got %0b want 0", o_rsp_v); end
      checkCount++; if (o_cnt !== 5'd0) begin errCount++; $display("FAIL rstmid_cnt: got %0d want 0", o_cnt); end
      @(negedge clk);
      reset = 1'b0; o_rsp_r = 1'b1;
      for (int k = 0; k < 64; k++) begin
         @(negedge clk);
         checkCount++; if (o_rsp_v !== 1'b0) begin errCount++; $display("FAIL rstmid_stale %0d: got %0b want 0", k, o_rsp_v); end
      end
      o_rsp_r = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_misaligned();
      test_full_dequeue();
      test_wrap_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
